sha256_digest_reader: RTL
=========================

# sha256_digest_reader

Output-side counterpart of the 32-bit load-enable register bank. It captures the final 256-bit hash state (H0..H7) in one cycle when loading is signalled. It then streams the state out as eight 32-bit words over a valid/ready handshake, H0 first. It sits between the hash-state registers and the host/output interface of the SHA-256 core.

## Interface
- `WORDS`, default 8: number of 32-bit words per digest; the counter width is $clog2(WORDS).
- `CLK` input, 1 bit: single clock; all state changes on the rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: capture pulse; samples `digest_i` when the block is in IDLE.
- `digest_i` input, 32*WORDS bits: hash state; H0 = [32*WORDS-1 -: 32], and the last word is [31:0].
- `dout_ready` input, 1 bit: downstream accepts the current word.
- `dout_valid` output, 1 bit: `dout_data` holds a valid word.
- `dout_data` output, 32 bits: current digest word.
- `dout_last` output, 1 bit: the current word is word WORDS-1; qualified by `dout_valid`.
- `busy` output, 1 bit: high in SEND and DONE.
- `done` output, 1 bit: one-cycle pulse after the final word is accepted.

## Operation
- Internal storage:
  - a 32*WORDS-bit capture buffer;
  - a word index `idx`;
  - a 2-bit state register.
- The FSM has three states: IDLE, SEND and DONE.
  - **IDLE**: `start`=1 loads `digest_i` into the buffer, clears `idx` to 0 and moves to SEND. `start`=0 holds IDLE.
  - **SEND**: `dout_valid`=1 and `dout_data` = buffer word `idx`.
    - A transfer occurs on a cycle with `dout_valid` && `dout_ready`.
    - A transfer with `idx` < WORDS-1 increments `idx`.
    - A transfer with `idx` = WORDS-1 moves to DONE.
    - No transfer: hold state, `idx` and `dout_data`.
  - **DONE**: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in SEND and DONE. The buffer is never overwritten mid-stream, even if `digest_i` changes.
- The buffer captures only at the IDLE->SEND edge, so `digest_i` may change freely after that edge.
- `dout_data` is 0 whenever `dout_valid`=0.
- `dout_last` = (state == SEND) && (`idx` == WORDS-1).
- `idx` does not wrap: exactly WORDS transfers occur per capture.

## Timing
- Reset values, asynchronous on `RST`=1:
  - state = IDLE, `idx` = 0, buffer = 0;
  - `dout_valid` = 0, `dout_data` = 0, `dout_last` = 0, `busy` = 0, `done` = 0.
- `RST` asserted mid-stream aborts the stream immediately. There is no `done` pulse, and remaining words are discarded.
- Latency:
  - `start` sampled at edge N puts word 0 on `dout_data` with `dout_valid`=1 after edge N.
  - With `dout_ready` tied high, words 0..7 appear in 8 consecutive cycles.
  - `done` pulses in the cycle after the final transfer.
  - `start` is accepted again the cycle after `done`, at the earliest.
- Minimum period from one capture to the next: WORDS+2 cycles.
- Handshake rules:
  - `dout_valid` never drops and `dout_data` never changes while `dout_valid`=1 and `dout_ready`=0.
  - `dout_ready` has no effect outside SEND.
- Simultaneous events:
  - `start`=1 in the same cycle as the final transfer is ignored.
  - `start`=1 during the `done` cycle is ignored.
  - `start` must be re-asserted in IDLE.
- All outputs are registered or decoded from registers only; there is no combinational path from an input to an output.

## Configuration
- `DIGEST_BYTESWAP_EN` defined: each emitted word is byte-reversed, so `dout_data` = {w[7:0], w[15:8], w[23:16], w[31:24]} for little-endian hosts.
  - The swap is applied on the output path only; buffer contents are unchanged.
- Not defined: words are emitted big-endian exactly as captured. This is the default.

## Test plan
- **Reset:** assert `RST` with stimulus active, then deassert.
  - Required: all outputs 0, `busy`=0.
  - Required: no `dout_valid` until `start`.
- **Streaming:** `digest_i` = SHA-256("abc"), `start` pulse, `dout_ready`=1.
  - Required: `dout_data` = ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad on consecutive cycles.
  - Required: `dout_last` only on f20015ad, then `done` for 1 cycle.
- **Backpressure:** same digest, `dout_ready` toggled 1,0,0,1,...
  - Required: each word held stable while `dout_ready`=0.
  - Required: no word skipped or duplicated; sequence identical to the streaming test.
- **Ignored start:** pulse `start` with a different `digest_i` during SEND and again in the `done` cycle.
  - Required: the stream is unaffected and the block returns to IDLE.
  - Required: a later `start` captures the new digest.
- **Reset mid-stream:** assert `RST` after word 3 is accepted.
  - Required: outputs 0 immediately, no `done`.
  - Required: a fresh `start` streams from word 0.
- **Byte swap:** with `DIGEST_BYTESWAP_EN` defined, run the streaming test.
  - Required: first word bf1678ba, last word ad1500f2.

Source files
------------

// File: rtl/sha256_digest_reader.sv
// rtl/sha256_digest_reader.sv - captures a SHA-256 hash state and streams it out word by word
//
// Purpose:
//   Captures the 32*WORDS-bit hash state (H0..H{WORDS-1}) in one cycle on
//   `start` while IDLE. It then emits one 32-bit word per accepted
//   valid/ready transfer, H0 first, and pulses `done` for one cycle after the
//   final word.
//
// Optional feature:
//   DIGEST_BYTESWAP_EN - when defined, every emitted word is byte-reversed on
//   the output path (for little-endian hosts); the buffer is not altered.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   start        capture pulse, honoured only in IDLE
//   digest_i     hash state, H0 in the top 32 bits
//   dout_ready   downstream accepts the current word
//   dout_valid   dout_data holds a valid word
//   dout_data    current digest word, 0 when not valid
//   dout_last    current word is the final word
//   busy         high while streaming or signalling done
//   done         one-cycle pulse after the final word is accepted

module sha256_digest_reader #(
    parameter int WORDS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   digest_i,
    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic [31:0]           dout_data,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [32*WORDS-1:0] cap_buf;
    logic [31:0]         word;
    logic [31:0]         word_out;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= '0;
            cap_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The only point where the buffer is written, so digest_i
                    // is free to change for the rest of the stream.
                    if (start) begin
                        cap_buf <= digest_i;
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Word idx counts from the top of the buffer: idx 0 is H0.
    always_comb begin
        word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) begin
                word = cap_buf[32*(WORDS-1-i) +: 32];
            end
        end
    end

`ifdef DIGEST_BYTESWAP_EN
    assign word_out = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    assign word_out = word;
`endif

    // All outputs decode registered state only; no input reaches an output.
    assign dout_valid = (state == SEND);
    assign dout_data  = dout_valid ? word_out : 32'h0;
    assign dout_last  = dout_valid && (idx == LAST_IDX);
    assign busy       = (state == SEND) || (state == DONE);
    assign done       = (state == DONE);

endmodule
